pc_sequencer_mt: RTL and testbench

//  Multi-hart PC/commit sequencer: next generation of the single-hart PC register and write-back PC mux.

---
 rtl/arvi_seq_pkg.sv | 18 +
 rtl/rr_next_hart.sv | 28 ++
 rtl/pc_sequencer_mt.sv | 124 ++++++++++++
 tb/tb_pc_sequencer_mt.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/arvi_seq_pkg.sv
// rtl/arvi_seq_pkg.sv - shared types and helpers for the multi-hart PC sequencer
package arvi_seq_pkg;

  localparam int HART_IDX_MAX_W = 8;

  typedef logic [HART_IDX_MAX_W-1:0] hart_idx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } seq_state_e;

  // Index width for n hart contexts; a single hart still gets one bit.
  function automatic int hart_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_next_hart.sv
// rtl/rr_next_hart.sv - picks the next enabled hart after cur, wrapping; cur itself is the last resort
module rr_next_hart
  import arvi_seq_pkg::*;
#(
  parameter int N_HARTS = 4,
  parameter int HW      = hart_w(N_HARTS)
) (
  input  logic [HW-1:0]      cur,
  input  logic [N_HARTS-1:0] en,
  output logic [HW-1:0]      idx,
  output logic               any
);

  // Walk offsets from farthest to nearest so the nearest enabled hart wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = N_HARTS; k >= 1; k--) begin
      for (int i = 0; i < N_HARTS; i++) begin
        if ((i == ((int'(cur) + k) % N_HARTS)) && en[i]) begin
          idx = HW'(i);
          any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pc_sequencer_mt.sv
// rtl/pc_sequencer_mt.sv - round-robin multi-hart PC/commit sequencer with per-hart retire counters
// Optional timer-interrupt redirect enabled by defining ARVI_PC_TIP_EN.
`ifndef PC_RESET
`define PC_RESET 32'h0
`endif
module pc_sequencer_mt
  import arvi_seq_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int N_HARTS = 4,
  parameter logic [XLEN-1:0] PC_RESET = `PC_RESET,
  localparam int HW = hart_w(N_HARTS)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_HARTS-1:0] i_hart_en,
  output logic               o_valid,
  output logic [XLEN-1:0]    o_pc,
  output logic [HW-1:0]      o_hart,
  input  logic               i_stall,
  input  logic [XLEN-1:0]    i_next_pc,
  input  logic               i_trap,
  input  logic               i_eret,
  input  logic [XLEN-1:0]    i_tvec,
  input  logic [XLEN-1:0]    i_epc,
`ifdef ARVI_PC_TIP_EN
  input  logic [N_HARTS-1:0] i_tip,
  input  logic [N_HARTS-1:0] i_tip_en,
  output logic               o_irq_taken,
  output logic [XLEN-1:0]    o_irq_epc,
`endif
  output logic               o_ex_inst_addr,
  output logic [XLEN-1:0]    o_badaddr,
  output logic               o_commit,
  output logic [63:0]        o_instret
);

  seq_state_e      state, state_nx;
  logic [HW-1:0]   cur, cur_nx, pick_cur, pick_idx;
  logic            pick_any;
  logic [XLEN-1:0] pc_q [N_HARTS];
  logic [63:0]     instret_q [N_HARTS];
  logic            misalign, irq, retire;
  logic [XLEN-1:0] pc_nx;

  // From IDLE, searching "after N_HARTS-1" yields the lowest enabled hart.
  assign pick_cur = (state == IDLE) ? HW'(N_HARTS - 1) : cur;

  rr_next_hart #(
    .N_HARTS(N_HARTS),
    .HW     (HW)
  ) u_rr_next_hart (
    .cur(pick_cur),
    .en (i_hart_en),
    .idx(pick_idx),
    .any(pick_any)
  );

  assign o_valid   = (state == ISSUE);
  assign o_commit  = o_valid && !i_stall;
  assign o_pc      = pc_q[cur];
  assign o_hart    = cur;
  assign o_instret = instret_q[cur];

  assign misalign       = o_commit && !i_trap && !i_eret && (|i_next_pc[1:0]);
  assign o_ex_inst_addr = misalign;
  assign o_badaddr      = misalign ? i_next_pc : '0;

`ifdef ARVI_PC_TIP_EN
  assign irq         = o_commit && i_tip[cur] && i_tip_en[cur] && !i_trap && !misalign;
  assign o_irq_taken = irq;
  assign o_irq_epc   = irq ? (i_eret ? i_epc : i_next_pc) : '0;
`else
  assign irq = 1'b0;
`endif

  // Trapped and misaligned instructions do not retire; interrupted ones do.
  assign retire = o_commit && !i_trap && !misalign;

  always_comb begin
    pc_nx = i_next_pc;
    if (i_trap || misalign || irq) pc_nx = i_tvec;
    else if (i_eret)               pc_nx = i_epc;
  end

  always_comb begin
    state_nx = state;
    cur_nx   = cur;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nx = ISSUE;
          cur_nx   = pick_idx;
        end
      end
      ISSUE: begin
        if (o_commit) begin
          if (pick_any) cur_nx = pick_idx;
          else          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state <= IDLE;
      cur   <= '0;
      for (int i = 0; i < N_HARTS; i++) begin
        pc_q[i]      <= PC_RESET;
        instret_q[i] <= 64'd0;
      end
    end else begin
      state <= state_nx;
      cur   <= cur_nx;
      if (o_commit) begin
        pc_q[cur] <= pc_nx;
        if (retire) instret_q[cur] <= instret_q[cur] + 64'd1;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer_mt.sv
// tb/tb_pc_sequencer_mt.sv - self-checking bench for pc_sequencer_mt against a behavioural hart model
`ifndef PC_RESET
`define PC_RESET 32'h0
`endif
module tb_pc_sequencer_mt;

  localparam int N = 4;
  localparam logic [31:0] PCR = `PC_RESET;

  logic        i_clk, i_rst, i_stall, i_trap, i_eret;
  logic [N-1:0] i_hart_en;
  logic [31:0] i_next_pc, i_tvec, i_epc;
  logic        o_valid, o_ex_inst_addr, o_commit;
  logic [31:0] o_pc, o_badaddr;
  logic [1:0]  o_hart;
  logic [63:0] o_instret;
`ifdef ARVI_PC_TIP_EN
  logic [N-1:0] i_tip, i_tip_en;
  logic         o_irq_taken;
  logic [31:0]  o_irq_epc;
  assign i_tip    = '0;
  assign i_tip_en = '0;
`endif

  pc_sequencer_mt #(.XLEN(32), .N_HARTS(N)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_hart_en(i_hart_en),
    .o_valid(o_valid), .o_pc(o_pc), .o_hart(o_hart),
    .i_stall(i_stall), .i_next_pc(i_next_pc), .i_trap(i_trap), .i_eret(i_eret),
    .i_tvec(i_tvec), .i_epc(i_epc),
`ifdef ARVI_PC_TIP_EN
    .i_tip(i_tip), .i_tip_en(i_tip_en), .o_irq_taken(o_irq_taken), .o_irq_epc(o_irq_epc),
`endif
    .o_ex_inst_addr(o_ex_inst_addr), .o_badaddr(o_badaddr),
    .o_commit(o_commit), .o_instret(o_instret)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference: per-hart PC and retire count, current hart, and whether an instruction is presented.
  logic [31:0] m_pc [N];
  logic [63:0] m_ir [N];
  int          m_cur;
  bit          m_act;
  int          n_chk, n_fail;

  task automatic tick();
    bit found;
    bit mis;
    if (!i_rst) begin
      for (int i = 0; i < N; i++) begin m_pc[i] = PCR; m_ir[i] = 64'd0; end
      m_cur = 0;
      m_act = 0;
    end else if (!m_act) begin
      found = 0;
      for (int i = 0; i < N; i++)
        if (!found && i_hart_en[i]) begin found = 1; m_cur = i; m_act = 1; end
    end else if (!i_stall) begin
      mis = !i_trap && !i_eret && (i_next_pc % 4 != 0);
      if (i_trap || mis) m_pc[m_cur] = i_tvec;
      else if (i_eret)   m_pc[m_cur] = i_epc;
      else               m_pc[m_cur] = i_next_pc;
      if (!i_trap && !mis) m_ir[m_cur] = m_ir[m_cur] + 64'd1;
      found = 0;
      for (int k = 1; k <= N; k++)
        if (!found && i_hart_en[(m_cur + k) % N]) begin found = 1; m_cur = (m_cur + k) % N; end
      if (!found) m_act = 0;
    end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic drive_normal();
    i_stall = 0; i_trap = 0; i_eret = 0;
    i_next_pc = m_pc[m_cur] + 32'd4;
    #1;
  endtask

  task automatic test_reset();
    i_rst = 0; i_hart_en = '0; i_tvec = 32'h100; i_epc = 32'h200;
    drive_normal();
    tick(); tick();
    n_chk += 4;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", o_valid); end
    if (o_pc !== PCR) begin n_fail++; $display("FAIL reset_pc got %h want %h", o_pc, PCR); end
    if (o_hart !== 2'd0) begin n_fail++; $display("FAIL reset_hart got %0d want 0", o_hart); end
    if (o_instret !== 64'd0) begin n_fail++; $display("FAIL reset_instret got %0d want 0", o_instret); end
    i_rst = 1;
  endtask

  task automatic test_round_robin();
    i_hart_en = 4'b1111;
    drive_normal();
    tick();
    for (int i = 0; i < 5; i++) begin
      drive_normal();
      n_chk += 4;
      if (o_hart !== 2'(i % 4)) begin n_fail++; $display("FAIL rr_hart[%0d] got %0d want %0d", i, o_hart, i % 4); end
      if (o_pc !== ((i == 4) ? PCR + 32'd4 : PCR)) begin n_fail++; $display("FAIL rr_pc[%0d] got %h", i, o_pc); end
      if (o_commit !== 1'b1) begin n_fail++; $display("FAIL rr_commit[%0d] got %0b want 1", i, o_commit); end
      if (o_badaddr !== 32'd0) begin n_fail++; $display("FAIL rr_badaddr[%0d] got %h want 0", i, o_badaddr); end
      tick();
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      i_stall = 1; i_trap = 1; i_eret = 0; i_next_pc = 32'hdead_beef; #1;
      n_chk += 4;
      if (o_pc !== PCR + 32'd4) begin n_fail++; $display("FAIL stall_pc got %h want %h", o_pc, PCR + 32'd4); end
      if (o_hart !== 2'd1) begin n_fail++; $display("FAIL stall_hart got %0d want 1", o_hart); end
      if (o_commit !== 1'b0 || o_ex_inst_addr !== 1'b0) begin n_fail++; $display("FAIL stall_commit got %0b/%0b want 0/0", o_commit, o_ex_inst_addr); end
      if (o_instret !== 64'd1) begin n_fail++; $display("FAIL stall_instret got %0d want 1", o_instret); end
      tick();
    end
    for (int i = 0; i < 4; i++) begin drive_normal(); tick(); end
    n_chk += 3;
    if (o_hart !== 2'd1) begin n_fail++; $display("FAIL stall_return_hart got %0d want 1", o_hart); end
    if (o_instret !== 64'd2) begin n_fail++; $display("FAIL stall_instret_after got %0d want 2", o_instret); end
    if (o_pc !== PCR + 32'd8) begin n_fail++; $display("FAIL stall_pc_after got %h want %h", o_pc, PCR + 32'd8); end
  endtask

  task automatic test_trap_eret();
    i_stall = 0; i_trap = 1; i_eret = 1; i_tvec = 32'h100; i_epc = 32'h555; i_next_pc = 32'h2000; #1;
    n_chk += 2;
    if (o_ex_inst_addr !== 1'b0) begin n_fail++; $display("FAIL trap_eret_exc got %0b want 0", o_ex_inst_addr); end
    if (o_commit !== 1'b1) begin n_fail++; $display("FAIL trap_eret_commit got %0b want 1", o_commit); end
    tick();
    for (int i = 0; i < 3; i++) begin drive_normal(); tick(); end
    n_chk += 2;
    if (o_pc !== 32'h100) begin n_fail++; $display("FAIL trap_eret_pc got %h want 00000100", o_pc); end
    if (o_instret !== 64'd2) begin n_fail++; $display("FAIL trap_eret_instret got %0d want 2", o_instret); end
  endtask

  task automatic test_misalign();
    i_stall = 0; i_trap = 0; i_eret = 0; i_tvec = 32'h300; i_next_pc = 32'h1002; #1;
    n_chk += 2;
    if (o_ex_inst_addr !== 1'b1) begin n_fail++; $display("FAIL misalign_exc got %0b want 1", o_ex_inst_addr); end
    if (o_badaddr !== 32'h1002) begin n_fail++; $display("FAIL misalign_badaddr got %h want 00001002", o_badaddr); end
    tick();
    for (int i = 0; i < 3; i++) begin drive_normal(); tick(); end
    n_chk += 2;
    if (o_pc !== 32'h300) begin n_fail++; $display("FAIL misalign_pc got %h want 00000300", o_pc); end
    if (o_instret !== 64'd2) begin n_fail++; $display("FAIL misalign_instret got %0d want 2", o_instret); end
  endtask

  task automatic test_enable_mask();
    i_hart_en = 4'b0101;
    drive_normal(); tick();
    drive_normal(); tick();
    for (int i = 0; i < 3; i++) begin
      drive_normal();
      n_chk++;
      if (o_hart !== ((i == 1) ? 2'd2 : 2'd0)) begin n_fail++; $display("FAIL mask_order[%0d] got %0d", i, o_hart); end
      tick();
    end
    i_hart_en = 4'b0000;
    drive_normal(); tick();
    for (int i = 0; i < 2; i++) begin
      #1;
      n_chk++;
      if (o_valid !== 1'b0) begin n_fail++; $display("FAIL park_valid[%0d] got %0b want 0", i, o_valid); end
      tick();
    end
    i_hart_en = 4'b1000;
    drive_normal(); tick();
    #1;
    n_chk += 4;
    if (o_valid !== 1'b1) begin n_fail++; $display("FAIL resume_valid got %0b want 1", o_valid); end
    if (o_hart !== 2'd3) begin n_fail++; $display("FAIL resume_hart got %0d want 3", o_hart); end
    if (o_pc !== PCR + 32'd16) begin n_fail++; $display("FAIL resume_pc got %h want %h", o_pc, PCR + 32'd16); end
    if (o_instret !== 64'd4) begin n_fail++; $display("FAIL resume_instret got %0d want 4", o_instret); end
  endtask

  task automatic test_random();
    logic [31:0] r;
    bit e_commit, e_mis;
    for (int c = 0; c < 3000; c++) begin
      i_rst = ($urandom_range(199) != 0);
      if ($urandom_range(7) == 0) i_hart_en = N'($urandom);
      i_stall = ($urandom_range(3) == 0);
      i_trap  = ($urandom_range(9) == 0);
      i_eret  = ($urandom_range(7) == 0);
      r = $urandom;
      i_next_pc = ($urandom_range(4) == 0) ? r : {r[31:2], 2'b00};
      r = $urandom; i_tvec = {r[31:2], 2'b00};
      r = $urandom; i_epc  = {r[31:2], 2'b00};
      #1;
      e_commit = m_act && !i_stall;
      e_mis    = e_commit && !i_trap && !i_eret && (i_next_pc % 4 != 0);
      n_chk += 7;
      if (o_valid !== m_act) begin n_fail++; $display("FAIL rnd_valid c=%0d got %0b want %0b", c, o_valid, m_act); end
      if (o_hart !== 2'(m_cur)) begin n_fail++; $display("FAIL rnd_hart c=%0d got %0d want %0d", c, o_hart, m_cur); end
      if (o_pc !== m_pc[m_cur]) begin n_fail++; $display("FAIL rnd_pc c=%0d got %h want %h", c, o_pc, m_pc[m_cur]); end
      if (o_commit !== e_commit) begin n_fail++; $display("FAIL rnd_commit c=%0d got %0b want %0b", c, o_commit, e_commit); end
      if (o_ex_inst_addr !== e_mis) begin n_fail++; $display("FAIL rnd_exc c=%0d got %0b want %0b", c, o_ex_inst_addr, e_mis); end
      if (o_badaddr !== (e_mis ? i_next_pc : 32'd0)) begin n_fail++; $display("FAIL rnd_badaddr c=%0d got %h", c, o_badaddr); end
      if (o_instret !== m_ir[m_cur]) begin n_fail++; $display("FAIL rnd_instret c=%0d got %0d want %0d", c, o_instret, m_ir[m_cur]); end
      tick();
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    m_cur = 0; m_act = 0;
    i_rst = 0; i_hart_en = '0; i_stall = 0; i_trap = 0; i_eret = 0;
    i_next_pc = '0; i_tvec = '0; i_epc = '0;
    @(negedge i_clk);
    test_reset();
    test_round_robin();
    test_stall();
    test_trap_eret();
    test_misalign();
    test_enable_mask();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
